// File: rtl/binary_vector_mult_arbiter.sv
// Round-robin arbiter sharing one activation x binary-weight vector multiplier between
// NUM_REQ requesters; an in-order tag FIFO steers each product back to its originator.
module binary_vector_mult_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned IN_SIZE         = 4,
   parameter int unsigned IN_WIDTH        = 32,
   parameter int unsigned WEIGHT_WIDTH    = 1,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_REQ*IN_SIZE*IN_WIDTH-1:0]      req_data,
   input  logic [NUM_REQ*IN_SIZE*WEIGHT_WIDTH-1:0]  req_weight,
   input  logic [NUM_REQ-1:0]                       req_valid,
   output logic [NUM_REQ-1:0]                       req_ready,
   output logic [IN_SIZE*IN_WIDTH-1:0]              mult_data_in,
   output logic                                     mult_data_in_valid,
   input  logic                                     mult_data_in_ready,
   output logic [IN_SIZE*WEIGHT_WIDTH-1:0]          mult_weight,
   output logic                                     mult_weight_valid,
   input  logic                                     mult_weight_ready,
   input  logic [IN_SIZE*IN_WIDTH-1:0]              mult_data_out,
   input  logic                                     mult_data_out_valid,
   output logic                                     mult_data_out_ready,
   output logic [IN_SIZE*IN_WIDTH-1:0]              rsp_data,
   output logic [NUM_REQ-1:0]                       rsp_valid,
   input  logic [NUM_REQ-1:0]                       rsp_ready,
   output logic                                     err
);

   localparam int unsigned VEC_W = IN_SIZE * IN_WIDTH;
   localparam int unsigned WV_W  = IN_SIZE * WEIGHT_WIDTH;
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
   logic [IDX_W-1:0]  grant;
   logic              granted;
   logic              issue_valid;
   logic              fire;
   int unsigned       cand;
   logic [IDX_W-1:0]  cand_idx;

   logic [IDX_W-1:0]  tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [IDX_W-1:0]  head;
   logic              empty, full, push, pop;

   // Grant: frozen index while locked, else first valid request from rr_ptr onwards
   always_comb begin
      granted  = 1'b0;
      grant    = lock_idx_q;
      cand     = 0;
      cand_idx = '0;
      if (state_q == ARB_LOCKED) begin
         granted = 1'b1;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!granted && req_valid[cand_idx]) begin
               granted = 1'b1;
               grant   = cand_idx;
            end
         end
      end
   end

   always_comb begin
      mult_data_in = '0;
      mult_weight  = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (grant == IDX_W'(r)) begin
            mult_data_in = req_data[r*VEC_W +: VEC_W];
            mult_weight  = req_weight[r*WV_W +: WV_W];
         end
      end
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));

   // Full blocks issue on the registered count so a same-cycle pop cannot race a push
   assign issue_valid        = rst & granted & ~full;
   assign mult_data_in_valid = issue_valid;
   assign mult_weight_valid  = issue_valid;
   assign fire               = issue_valid & mult_data_in_ready & mult_weight_ready;
   assign push               = fire;

   always_comb begin
      req_ready = '0;
      if (fire) req_ready[grant] = 1'b1;
   end

   assign head                = tag_mem[rd_ptr_q];
   assign mult_data_out_ready = ~empty & rsp_ready[head];
   assign pop                 = mult_data_out_valid & mult_data_out_ready;
   assign rsp_data            = mult_data_out;

   always_comb begin
      rsp_valid = '0;
      if (mult_data_out_valid && !empty) rsp_valid[head] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      count_d    = count_q;
      if (fire) begin
         state_d  = ARB_OPEN;
         rr_ptr_d = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
      end else if (issue_valid) begin
         state_d    = ARB_LOCKED;
         lock_idx_d = grant;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ARB_OPEN;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         count_q    <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (mult_data_out_valid && empty) err <= 1'b1;
      end
   end

   // Tag storage needs no reset: entries are only read when count is non-zero
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_q] <= grant;
   end

endmodule

// File: tb/tb_binary_vector_mult_arbiter.sv
// Randomized scoreboard bench for binary_vector_mult_arbiter with a register-slice multiplier stub.
module tb_binary_vector_mult_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned S    = 4;
   localparam int unsigned W    = 32;
   localparam int unsigned MAXO = 4;
   localparam int unsigned VW   = S * W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N*VW-1:0] req_data;
   logic [N*S-1:0]  req_weight;
   logic [N-1:0]    req_valid, req_ready;
   logic [VW-1:0]   mult_data_in;
   logic            mult_data_in_valid, mult_data_in_ready;
   logic [S-1:0]    mult_weight;
   logic            mult_weight_valid, mult_weight_ready;
   logic [VW-1:0]   mult_data_out;
   logic            mult_data_out_valid, mult_data_out_ready;
   logic [VW-1:0]   rsp_data;
   logic [N-1:0]    rsp_valid, rsp_ready;
   logic            err;

   logic [VW-1:0]   drv_data [N];
   logic [S-1:0]    drv_w [N];
   logic [N-1:0]    drv_valid;
   logic [N-1:0]    acc;
   logic            stall, inj;
   logic            sl_valid, sl_in_ready;
   logic [VW-1:0]   sl_data;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int unsigned   owner;
      logic [VW-1:0] prod;
   } exp_t;
   exp_t m_q[$];
   int unsigned m_rr, m_lidx, g;
   bit m_lock, m_err, g_ok, e_iv, e_fire, e_mor;
   logic [N-1:0] e_rv, e_rr;

   binary_vector_mult_arbiter #(
      .NUM_REQ(N), .IN_SIZE(S), .IN_WIDTH(W), .WEIGHT_WIDTH(1), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst_n),
      .req_data(req_data), .req_weight(req_weight), .req_valid(req_valid), .req_ready(req_ready),
      .mult_data_in(mult_data_in), .mult_data_in_valid(mult_data_in_valid),
      .mult_data_in_ready(mult_data_in_ready),
      .mult_weight(mult_weight), .mult_weight_valid(mult_weight_valid),
      .mult_weight_ready(mult_weight_ready),
      .mult_data_out(mult_data_out), .mult_data_out_valid(mult_data_out_valid),
      .mult_data_out_ready(mult_data_out_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .err(err)
   );

   always_comb begin
      for (int r = 0; r < N; r++) begin
         req_data[r*VW +: VW]  = drv_data[r];
         req_weight[r*S +: S]  = drv_w[r];
      end
   end
   assign req_valid = drv_valid;

   // Multiplier stand-in: one register slice, weight 1 passes x, weight 0 negates x
   assign sl_in_ready         = !sl_valid || mult_data_out_ready;
   assign mult_data_in_ready  = sl_in_ready && !stall;
   assign mult_weight_ready   = sl_in_ready && !stall;
   assign mult_data_out_valid = sl_valid || inj;
   assign mult_data_out       = sl_data;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_valid <= 1'b0;
      end else if (sl_in_ready) begin
         sl_valid <= mult_data_in_valid && mult_weight_valid && mult_data_in_ready;
         for (int i = 0; i < S; i++)
            sl_data[i*W +: W] <= mult_weight[i] ? mult_data_in[i*W +: W] : -mult_data_in[i*W +: W];
      end
   end

   function automatic logic [VW-1:0] ref_prod(input logic [VW-1:0] x, input logic [S-1:0] w);
      logic [VW-1:0] p;
      int a;
      for (int i = 0; i < S; i++) begin
         a = $signed(x[i*W +: W]);
         p[i*W +: W] = W'(a * (w[i] ? 1 : -1));
      end
      return p;
   endfunction

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor + reference model, evaluated mid-cycle for the upcoming rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0; acc = '0;
         chk("rst_req_ready", VW'(req_ready), '0);
         chk("rst_in_valid", VW'({mult_data_in_valid, mult_weight_valid}), '0);
         chk("rst_rsp_valid", VW'(rsp_valid), '0);
         chk("rst_out_ready", VW'(mult_data_out_ready), '0);
         chk("rst_err", VW'(err), '0);
      end else begin
         g_ok = 0; g = 0;
         if (m_lock) begin
            g_ok = 1; g = m_lidx;
         end else begin
            for (int i = 0; i < N; i++)
               if (!g_ok && drv_valid[(m_rr + i) % N]) begin g_ok = 1; g = (m_rr + i) % N; end
         end
         e_iv   = g_ok && (m_q.size() < MAXO);
         e_fire = e_iv && mult_data_in_ready && mult_weight_ready;
         e_rr   = e_fire ? N'(1) << g : '0;
         chk("in_valid", VW'(mult_data_in_valid), VW'(e_iv));
         chk("weight_valid", VW'(mult_weight_valid), VW'(e_iv));
         chk("req_ready", VW'(req_ready), VW'(e_rr));
         if (e_iv) begin
            chk("in_data", mult_data_in, drv_data[g]);
            chk("in_weight", VW'(mult_weight), VW'(drv_w[g]));
         end

         e_rv  = (mult_data_out_valid && m_q.size() != 0) ? N'(1) << m_q[0].owner : '0;
         e_mor = (m_q.size() != 0) && rsp_ready[m_q[0].owner];
         chk("rsp_valid", VW'(rsp_valid), VW'(e_rv));
         chk("out_ready", VW'(mult_data_out_ready), VW'(e_mor));
         chk("err", VW'(err), VW'(m_err));
         if (mult_data_out_valid && m_q.size() == 0) m_err = 1;
         if (mult_data_out_valid && e_mor) begin
            chk("rsp_data", rsp_data, m_q[0].prod);
            m_q.delete(0);
         end

         acc = '0;
         if (e_fire) begin
            m_q.push_back('{owner: g, prod: ref_prod(drv_data[g], drv_w[g])});
            acc[g] = 1'b1;
            m_rr   = (g + 1) % N;
            m_lock = 0;
         end else if (e_iv) begin
            m_lock = 1;
            m_lidx = g;
         end
      end
   end

   task automatic run(input logic [N-1:0] mask, input int unsigned pv, input int unsigned pr,
                      input int unsigned ps, input int cycles);
      repeat (cycles) begin
         @(posedge clk); #1;
         for (int r = 0; r < N; r++) begin
            if (acc[r]) drv_valid[r] = 1'b0;
            if (!drv_valid[r] && mask[r] && $urandom_range(99) < pv) begin
               drv_valid[r] = 1'b1;
               drv_data[r]  = {$urandom, $urandom, $urandom, $urandom};
               drv_w[r]     = S'($urandom);
            end
            rsp_ready[r] = ($urandom_range(99) < pr);
         end
         stall = ($urandom_range(99) < ps);
      end
   endtask

   task automatic drain();
      int k = 0;
      while ((m_q.size() != 0 || sl_valid || drv_valid != '0) && k < 60) begin
         run('0, 0, 100, 0, 1);
         k++;
      end
      chk("drain_done", VW'({m_q.size() != 0, sl_valid, drv_valid != '0}), '0);
   endtask

   initial begin
      drv_valid = '0;
      for (int r = 0; r < N; r++) begin drv_data[r] = '0; drv_w[r] = '0; end
      rsp_ready = '0; stall = 1'b0; inj = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      run(4'b0100, 100, 100, 0, 6);
      run(4'b0000, 0, 100, 0, 4);
      run(4'b1111, 100, 100, 0, 12);
      run(4'b1010, 100, 100, 70, 10);
      run(4'b1111, 100, 100, 60, 20);
      run(4'b1111, 100, 0, 0, 10);
      run(4'b1111, 100, 100, 0, 6);
      run(4'b1111, 60, 70, 30, 400);
      drain();
      @(posedge clk); #1 inj = 1'b1;
      @(posedge clk); #1 inj = 1'b0;
      run(4'b1111, 60, 80, 20, 100);
      run(4'b1111, 100, 0, 0, 6);
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run(4'b1111, 60, 80, 20, 150);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
